uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Transmit end of the UART byte interface: buffers bytes written on tx_wdata/tx_wten,
//  reports FIFO status back to the writer (e.g. loopback logic), and serializes each
//  byte onto the uart_tx pin as 8N1 (1 start, 8 data LSB first, 1 stop).
//  Sits between the user-side byte logic and the board TX pin; one clock domain.
// PARAMETERS
//  CLKS_PER_BIT  208  clk cycles per bit (24 MHz / 115200); legal range >= 2
//  FIFO_DEPTH    16   FIFO entries; power of 2, >= 2
//  ADDR_W        4    log2(FIFO_DEPTH); width of read/write pointers
// PORTS
//  clk               in   1  system clock, all logic on rising edge
//  rst               in   1  synchronous reset, active-high
//  tx_wdata          in   8  byte to enqueue
//  tx_wten           in   1  write enable, one byte per cycle when high
//  ovr_clr           in   1  clears sticky tx_fifo_overrun
//  tx_fifo_full      out  1  FIFO holds FIFO_DEPTH entries
//  tx_fifo_overrun   out  1  sticky: a write arrived while full
//  tx_fifo_underrun  out  1  constant 0; internal read is gated by not-empty
//  tx_busy           out  1  serializer not IDLE
//  uart_tx           out  1  serial line, registered, idles high
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): count=0, pointers=0, state=IDLE, uart_tx=1,
//   tx_fifo_full=0, tx_fifo_overrun=0, tx_busy=0; FIFO contents discarded.
//  Reset mid-frame: line forced high on the next edge; frame aborted, not resumed.
//  FIFO: count 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
//   tx_fifo_full = (count == FIFO_DEPTH), derived from the registered count.
//   Write accepted when tx_wten && !tx_fifo_full. Full is taken from the current count;
//   a write on a full cycle is dropped even if a pop occurs in the same cycle.
//   Simultaneous accepted write and pop: count unchanged, both pointers advance.
//   Dropped write sets tx_fifo_overrun. ovr_clr clears it; set wins over a same-cycle clear.
//  Serializer FSM states: IDLE, START, DATA, STOP. Baud counter counts 0..CLKS_PER_BIT-1
//   per bit. Bit index counts 0..7 in DATA.
//   IDLE: uart_tx=1. When count!=0: pop head into shift register, go to START, clear the counter.
//   START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit=0.
//   DATA: uart_tx=shift[0] for CLKS_PER_BIT cycles per bit, shift right. After bit 7, go to STOP.
//   STOP: uart_tx=1 for CLKS_PER_BIT cycles. On the last cycle, if count!=0, pop and go to
//    START (no idle gap); otherwise go to IDLE.
//  Latency: tx_wten high in cycle N into an empty FIFO while IDLE: count=1 after edge N,
//   pop at edge N+1, uart_tx low from edge N+2. Frame length = 10*CLKS_PER_BIT cycles.
//  tx_busy = (state != IDLE), registered alongside state.
//  Capacity: FIFO_DEPTH queued + 1 in the shift register.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=16 unless noted)
//  1 reset: hold rst 2 cycles -> uart_tx=1, full=0, overrun=0, busy=0; no frame.
//  2 single 0x55: one tx_wten pulse -> uart_tx low 2 cycles later; bits 1,0,1,0,1,0,1,0
//    of 4 cycles each; stop high; busy drops after 40 cycles.
//  3 back-to-back 0x00,0xFF,0xA5 on 3 consecutive cycles -> 3 contiguous frames in order,
//    no idle cycle between a stop bit and the next start bit.
//  4 overflow: 18 writes on consecutive cycles -> bytes 0..16 transmitted in order, byte 17
//    dropped; full=1 after write 16; overrun=1 and stays set until ovr_clr.
//  5 ovr_clr together with a write while full -> overrun stays 1; later ovr_clr alone clears it.
//  6 rst pulse during DATA bit 3 with 5 bytes queued -> uart_tx=1 next edge, count=0,
//    no further frames; a new 0x3C write afterwards transmits correctly.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Transmit side of the UART byte interface. Bytes written on tx_wdata/tx_wten
//   are buffered in a FIFO and serialized onto uart_tx as 8N1 frames (one start
//   bit, eight data bits LSB first, one stop bit). Single clock domain.
//
// Ports
//   clk               system clock, rising edge
//   rst               synchronous reset, active high
//   tx_wdata          byte to enqueue
//   tx_wten           write strobe, one byte per cycle
//   ovr_clr           clears the sticky overrun flag
//   tx_fifo_full      FIFO holds FIFO_DEPTH entries
//   tx_fifo_overrun   sticky: a write arrived while the FIFO was full
//   tx_fifo_underrun  always 0; the serializer only pops when not empty
//   tx_busy           serializer is not idle
//   uart_tx           registered serial line, idles high
//
// Serializer states
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | line high, waiting for a queued byte
//   S_START | start bit (line low) for CLKS_PER_BIT cycles
//   S_DATA  | data bits 0..7, shift[0] on the line, CLKS_PER_BIT each
//   S_STOP  | stop bit (line high); chains straight into the next byte

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 208,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_wdata,
    input  logic       tx_wten,
    input  logic       ovr_clr,
    output logic       tx_fifo_full,
    output logic       tx_fifo_overrun,
    output logic       tx_fifo_underrun,
    output logic       tx_busy,
    output logic       uart_tx
);

    localparam int                BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              push;
    logic              pop;
    logic              fifo_has_data;

    // Full comes from the registered count only, so a pop in the same cycle
    // does not rescue a write that lands on a full FIFO.
    assign tx_fifo_full     = (count == COUNT_FULL);
    assign tx_fifo_underrun = 1'b0;
    assign fifo_has_data    = (count != '0);
    assign push             = tx_wten && !tx_fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_wdata;
        end
    end

    // Set wins over a same-cycle clear so a drop is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_fifo_overrun <= 1'b0;
        end else if (tx_wten && tx_fifo_full) begin
            tx_fifo_overrun <= 1'b1;
        end else if (ovr_clr) begin
            tx_fifo_overrun <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    state_t            state;
    state_t            state_nxt;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_nxt;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_nxt;
    logic [7:0]        shift;
    logic [7:0]        shift_nxt;
    logic              tx_nxt;
    logic              busy_nxt;
    logic              baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_busy  <= 1'b0;
            uart_tx  <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
            tx_busy  <= busy_nxt;
            uart_tx  <= tx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        pop       = 1'b0;

        case (state)
            S_IDLE: begin
                if (fifo_has_data) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rd_ptr];
                    baud_nxt  = '0;
                    state_nxt = S_START;
                end
            end

            S_START: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = S_DATA;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    shift_nxt = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end else begin
                        bit_nxt = bit_idx + 1'b1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end

            S_STOP: begin
                if (baud_last) begin
                    baud_nxt = '0;
                    // Chain directly into the next start bit when more bytes wait.
                    if (fifo_has_data) begin
                        pop       = 1'b1;
                        shift_nxt = mem[rd_ptr];
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                baud_nxt  = '0;
            end
        endcase
    end

    // The line is driven from the current state, so it trails the state
    // register by one cycle; the busy flag tracks the state register itself.
    always_comb begin
        tx_nxt = 1'b1;
        case (state)
            S_IDLE:  tx_nxt = 1'b1;
            S_START: tx_nxt = 1'b0;
            S_DATA:  tx_nxt = shift[0];
            S_STOP:  tx_nxt = 1'b1;
            default: tx_nxt = 1'b1;
        endcase
    end

    assign busy_nxt = (state_nxt != S_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic [7:0] tx_wdata;
    logic       tx_wten;
    logic       ovr_clr;
    logic       tx_fifo_full;
    logic       tx_fifo_overrun;
    logic       tx_fifo_underrun;
    logic       tx_busy;
    logic       uart_tx;

    int tests = 0;
    int fails = 0;
    int frames_rx = 0;

    logic [7:0] sb[$];

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (16),
        .ADDR_W      (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .tx_wdata        (tx_wdata),
        .tx_wten         (tx_wten),
        .ovr_clr         (ovr_clr),
        .tx_fifo_full    (tx_fifo_full),
        .tx_fifo_overrun (tx_fifo_overrun),
        .tx_fifo_underrun(tx_fifo_underrun),
        .tx_busy         (tx_busy),
        .uart_tx         (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_idle(input int budget);
        repeat (3) @(negedge clk);
        for (int i = 0; i < budget; i++) begin
            if (!tx_busy) break;
            @(negedge clk);
        end
        check("wait_idle", tx_busy, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    // Line monitor: decodes frames at the negedge and compares them with the scoreboard.
    initial begin : monitor
        logic [9:0] f;
        logic       stable;
        logic       aborted;
        logic       have_start;
        logic [7:0] exp_b;
        have_start = 1'b0;
        forever begin
            if (!have_start) begin
                @(negedge clk);
                have_start = (!rst && uart_tx === 1'b0);
            end else begin
                have_start = 1'b0;
                stable     = 1'b1;
                aborted    = 1'b0;
                f          = '0;
                for (int j = 0; j < 10 * CPB; j++) begin
                    if (j > 0) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (j % CPB == 0) f[j / CPB] = uart_tx;
                    else if (uart_tx !== f[j / CPB]) stable = 1'b0;
                end
                if (!aborted) begin
                    frames_rx++;
                    check("mon_bit_stable", stable, 1'b1);
                    check("mon_stop_bit", f[9], 1'b1);
                    check("mon_frame_expected", sb.size() != 0, 1'b1);
                    if (sb.size() != 0) begin
                        exp_b = sb.pop_front();
                        check("mon_data", f[8:1], exp_b);
                    end
                    if (sb.size() != 0) begin
                        @(negedge clk);
                        if (!rst) begin
                            check("mon_no_idle_gap", uart_tx, 1'b0);
                            have_start = (uart_tx === 1'b0);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    initial begin : stim
        vec_t vecs[4];
        int   base;
        logic quiet;

        vecs[0] = '{data: 8'h55, frame: 10'b1_0101_0101_0};
        vecs[1] = '{data: 8'hC3, frame: 10'b1_1100_0011_0};
        vecs[2] = '{data: 8'h01, frame: 10'b1_0000_0001_0};
        vecs[3] = '{data: 8'h80, frame: 10'b1_1000_0000_0};

        rst      = 1'b1;
        tx_wdata = 8'h00;
        tx_wten  = 1'b0;
        ovr_clr  = 1'b0;

        // 1: reset
        repeat (2) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1'b1);
        check("rst_full", tx_fifo_full, 1'b0);
        check("rst_overrun", tx_fifo_overrun, 1'b0);
        check("rst_busy", tx_busy, 1'b0);
        check("underrun_zero", tx_fifo_underrun, 1'b0);
        rst = 1'b0;
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) quiet = 1'b0;
        end
        check("rst_no_frame", quiet, 1'b1);

        // 2: single-byte frames with exact timing
        for (int v = 0; v < 4; v++) begin
            tx_wdata = vecs[v].data;
            tx_wten  = 1'b1;
            sb.push_back(vecs[v].data);
            @(negedge clk);
            tx_wten = 1'b0;
            @(negedge clk);
            check("pre_start_high", uart_tx, 1'b1);
            check("busy_rise", tx_busy, 1'b1);
            for (int j = 0; j < 10; j++) begin
                for (int k = 0; k < CPB; k++) begin
                    @(negedge clk);
                    check($sformatf("v%0d_bit%0d", v, j), uart_tx, vecs[v].frame[j]);
                    if (j == 9 && k == CPB - 2) check("busy_last_cycle", tx_busy, 1'b1);
                    if (j == 9 && k == CPB - 1) check("busy_drop", tx_busy, 1'b0);
                end
            end
            repeat (3) @(negedge clk);
            check("single_sb_drained", sb.size(), 0);
        end

        // 3: back-to-back writes, contiguous frames
        base = frames_rx;
        for (int i = 0; i < 3; i++) begin
            tx_wdata = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'hA5;
            tx_wten  = 1'b1;
            sb.push_back(tx_wdata);
            @(negedge clk);
        end
        tx_wten = 1'b0;
        wait_idle(400);
        check("b2b_frames", frames_rx - base, 3);
        check("b2b_sb_drained", sb.size(), 0);

        // 4: overflow, 18 writes, byte 17 dropped
        base = frames_rx;
        for (int i = 0; i < 18; i++) begin
            tx_wdata = 8'(i);
            tx_wten  = 1'b1;
            if (i <= 16) sb.push_back(8'(i));
            @(negedge clk);
            if (i == 15) check("ovf_not_full_yet", tx_fifo_full, 1'b0);
            if (i == 16) check("ovf_full", tx_fifo_full, 1'b1);
            if (i == 16) check("ovf_no_overrun_yet", tx_fifo_overrun, 1'b0);
            if (i == 17) check("ovf_overrun_set", tx_fifo_overrun, 1'b1);
        end
        tx_wten = 1'b0;
        wait_idle(1000);
        check("ovf_frames", frames_rx - base, 17);
        check("ovf_sb_drained", sb.size(), 0);
        check("ovf_overrun_sticky", tx_fifo_overrun, 1'b1);
        check("ovf_full_clear", tx_fifo_full, 1'b0);

        // 5: ovr_clr versus a same-cycle dropped write
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        check("clr_alone_first", tx_fifo_overrun, 1'b0);
        base = frames_rx;
        for (int i = 0; i < 18; i++) begin
            tx_wdata = 8'h40 + 8'(i);
            tx_wten  = 1'b1;
            ovr_clr  = (i == 17);
            if (i <= 16) sb.push_back(8'h40 + 8'(i));
            @(negedge clk);
            if (i == 16) check("clr_full", tx_fifo_full, 1'b1);
            if (i == 17) check("set_wins_over_clr", tx_fifo_overrun, 1'b1);
        end
        tx_wten = 1'b0;
        ovr_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("overrun_held", tx_fifo_overrun, 1'b1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        check("clr_alone_clears", tx_fifo_overrun, 1'b0);
        wait_idle(1000);
        check("clr_frames", frames_rx - base, 17);
        check("clr_sb_drained", sb.size(), 0);

        // 6: reset during DATA bit 3 with bytes queued
        base = frames_rx;
        for (int i = 0; i < 5; i++) begin
            tx_wdata = 8'h10 + 8'(i);
            tx_wten  = 1'b1;
            sb.push_back(tx_wdata);
            @(negedge clk);
        end
        tx_wten = 1'b0;
        repeat (14) @(negedge clk);
        check("busy_before_rst", tx_busy, 1'b1);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midrst_uart_tx", uart_tx, 1'b1);
        check("midrst_busy", tx_busy, 1'b0);
        check("midrst_full", tx_fifo_full, 1'b0);
        rst = 1'b0;
        quiet = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) quiet = 1'b0;
        end
        check("midrst_no_frames", quiet, 1'b1);
        check("midrst_frames_none", frames_rx - base, 0);

        tx_wdata = 8'h3C;
        tx_wten  = 1'b1;
        sb.push_back(8'h3C);
        @(negedge clk);
        tx_wten = 1'b0;
        wait_idle(200);
        check("post_rst_frames", frames_rx - base, 1);
        check("post_rst_sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
